// File: rtl/square_frame_accum.sv
// square_frame_accum: accepts sets of four 4-bit squares, cross-checks them,
// sums sq_g over a FRAME_LEN-sample frame with saturation, and hands the
// frame sum downstream over valid/ready. Mismatch diagnostics persist across
// frames and clear only on reset.
module square_frame_accum #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned SUM_W     = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sq_g,
  input  logic [3:0]       sq_d,
  input  logic [3:0]       sq_if,
  input  logic [3:0]       sq_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             ovf,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int unsigned SCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [SCW-1:0] LAST = SCW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic             mism_q, mism_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             ovalid_q, ovalid_d;

  logic             accept;
  logic             differ;
  logic [SUM_W:0]   acc_sum;

  // Next-state, accumulation, cross-check and handshake decode
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    scnt_d   = scnt_q;
    mism_d   = mism_q;
    mcnt_d   = mcnt_q;
    ovalid_d = ovalid_q;

    in_ready = (state_q != DONE);
    accept   = in_valid & in_ready;
    acc_sum  = {1'b0, acc_q} + (SUM_W + 1)'(sq_g);
    differ   = (sq_d != sq_g) | (sq_if != sq_g) | (sq_c != sq_g);

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          // Carry out of the widened add means saturate; ovf stays set for the frame
          if (acc_sum[SUM_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_sum[SUM_W-1:0];
          end
          if (differ) begin
            mism_d = 1'b1;
            if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
          end
          if (scnt_q == LAST) begin
            state_d  = DONE;
            ovalid_d = 1'b1;
          end else begin
            state_d = ACCUM;
            scnt_d  = scnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          acc_d    = '0;
          ovf_d    = 1'b0;
          scnt_d   = '0;
          ovalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      scnt_q   <= '0;
      mism_q   <= 1'b0;
      mcnt_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      scnt_q   <= scnt_d;
      mism_q   <= mism_d;
      mcnt_q   <= mcnt_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign sum          = acc_q;
  assign ovf          = ovf_q;
  assign out_valid    = ovalid_q;
  assign mismatch     = mism_q;
  assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_square_frame_accum.sv
// Directed bench for square_frame_accum: default build, a narrow-sum build
// (SUM_W=4) and a single-sample-frame build (FRAME_LEN=1) share one stimulus.
module tb_square_frame_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] sq_g = '0, sq_d = '0, sq_if = '0, sq_c = '0;

  logic       a_in_ready, a_out_valid, a_ovf, a_mismatch;
  logic [7:0] a_sum;
  logic [3:0] a_mcnt;
  logic       b_in_ready, b_out_valid, b_ovf, b_mismatch;
  logic [3:0] b_sum;
  logic [3:0] b_mcnt;
  logic       c_in_ready, c_out_valid, c_ovf, c_mismatch;
  logic [7:0] c_sum;
  logic [3:0] c_mcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  square_frame_accum #(.FRAME_LEN(4), .SUM_W(8), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .sq_g(sq_g), .sq_d(sq_d), .sq_if(sq_if), .sq_c(sq_c),
    .out_valid(a_out_valid), .out_ready(out_ready), .sum(a_sum), .ovf(a_ovf),
    .mismatch(a_mismatch), .mismatch_cnt(a_mcnt)
  );

  square_frame_accum #(.FRAME_LEN(4), .SUM_W(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .sq_g(sq_g), .sq_d(sq_d), .sq_if(sq_if), .sq_c(sq_c),
    .out_valid(b_out_valid), .out_ready(out_ready), .sum(b_sum), .ovf(b_ovf),
    .mismatch(b_mismatch), .mismatch_cnt(b_mcnt)
  );

  square_frame_accum #(.FRAME_LEN(1), .SUM_W(8), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .sq_g(sq_g), .sq_d(sq_d), .sq_if(sq_if), .sq_c(sq_c),
    .out_valid(c_out_valid), .out_ready(out_ready), .sum(c_sum), .ovf(c_ovf),
    .mismatch(c_mismatch), .mismatch_cnt(c_mcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accepted-or-offered sample: drive for one edge, then drop in_valid
  task automatic send(input logic [3:0] g, input logic [3:0] d,
                      input logic [3:0] i, input logic [3:0] c);
    in_valid = 1'b1;
    sq_g = g; sq_d = d; sq_if = i; sq_c = c;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sum",   a_sum, 0);
    chk("rst_ovf",   a_ovf, 0);
    chk("rst_oval",  a_out_valid, 0);
    chk("rst_mism",  a_mismatch, 0);
    chk("rst_mcnt",  a_mcnt, 0);
    chk("rst_ready", a_in_ready, 1);

    // Frame {0,1,4,9} with out_ready high: one-cycle out_valid, sum 14
    out_ready = 1'b1;
    send(0, 0, 0, 0); send(1, 1, 1, 1); send(4, 4, 4, 4);
    chk("f1_part_sum", a_sum, 5);
    chk("f1_part_oval", a_out_valid, 0);
    send(9, 9, 9, 9);
    chk("f1_oval",  a_out_valid, 1);
    chk("f1_sum",   a_sum, 14);
    chk("f1_ovf",   a_ovf, 0);
    chk("f1_mism",  a_mismatch, 0);
    chk("f1_ready", a_in_ready, 0);
    chk("f1_b_sum", b_sum, 14);
    chk("f1_b_ovf", b_ovf, 0);
    tick();
    chk("f1_oval_drop", a_out_valid, 0);
    chk("f1_sum_clr",   a_sum, 0);
    chk("f1_ready_back", a_in_ready, 1);

    // Same frame, downstream stalls 5 cycles while upstream offers a sample
    out_ready = 1'b0;
    send(0, 0, 0, 0); send(1, 1, 1, 1); send(4, 4, 4, 4); send(9, 9, 9, 9);
    in_valid = 1'b1; sq_g = 9; sq_d = 9; sq_if = 9; sq_c = 9;
    for (int k = 0; k < 5; k++) begin
      chk("stall_oval",  a_out_valid, 1);
      chk("stall_sum",   a_sum, 14);
      chk("stall_ready", a_in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_hs_oval", a_out_valid, 0);
    chk("stall_hs_sum",  a_sum, 0);
    send(1, 1, 1, 1); send(1, 1, 1, 1); send(1, 1, 1, 1); send(1, 1, 1, 1);
    chk("f_ones_oval", a_out_valid, 1);
    chk("f_ones_sum",  a_sum, 4);
    tick();

    // Mismatch on one sample (sq_c differs); sq_g still summed
    send(4, 4, 4, 5); send(1, 1, 1, 1); send(1, 1, 1, 1); send(1, 1, 1, 1);
    chk("mm_sum",  a_sum, 7);
    chk("mm_flag", a_mismatch, 1);
    chk("mm_cnt",  a_mcnt, 1);
    tick();
    send(0, 0, 0, 0); send(0, 0, 0, 0); send(0, 0, 0, 0); send(0, 0, 0, 0);
    chk("mm_keep_flag", a_mismatch, 1);
    chk("mm_keep_cnt",  a_mcnt, 1);
    chk("mm_next_sum",  a_sum, 0);
    tick();

    // Saturation in the SUM_W=4 build; default build holds 36 unsaturated
    out_ready = 1'b0;
    send(9, 9, 9, 9); send(9, 9, 9, 9);
    chk("sat_mid_b_sum", b_sum, 15);
    chk("sat_mid_b_ovf", b_ovf, 1);
    chk("sat_mid_a_sum", a_sum, 18);
    send(9, 9, 9, 9); send(9, 9, 9, 9);
    chk("sat_b_sum",  b_sum, 15);
    chk("sat_b_ovf",  b_ovf, 1);
    chk("sat_b_oval", b_out_valid, 1);
    chk("sat_a_sum",  a_sum, 36);
    chk("sat_a_ovf",  a_ovf, 0);
    out_ready = 1'b1;
    tick();
    chk("sat_hs_b_ovf", b_ovf, 0);
    send(1, 1, 1, 1); send(0, 0, 0, 0); send(0, 0, 0, 0); send(0, 0, 0, 0);
    chk("sat_next_b_sum", b_sum, 1);
    chk("sat_next_b_ovf", b_ovf, 0);
    tick();

    // Reset mid-frame discards the partial sum and the diagnostics
    send(9, 9, 9, 9); send(9, 9, 9, 9);
    chk("pre_rst_sum", a_sum, 18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_sum",   a_sum, 0);
    chk("mid_rst_ovf",   a_ovf, 0);
    chk("mid_rst_oval",  a_out_valid, 0);
    chk("mid_rst_ready", a_in_ready, 1);
    chk("mid_rst_mism",  a_mismatch, 0);
    chk("mid_rst_mcnt",  a_mcnt, 0);
    send(4, 4, 4, 4); send(4, 4, 4, 4); send(4, 4, 4, 4); send(4, 4, 4, 4);
    chk("post_rst_sum",  a_sum, 16);
    chk("post_rst_oval", a_out_valid, 1);
    tick();

    // in_valid toggling: idle cycles add nothing
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 1, 1);
      if (i < 3) begin
        tick();
        chk("tog_sum",  a_sum, i + 1);
        chk("tog_oval", a_out_valid, 0);
      end
    end
    chk("tog_oval_rise", a_out_valid, 1);
    chk("tog_sum_final", a_sum, 4);
    tick();
    chk("tog_oval_hold", a_out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("tog_oval_drop", a_out_valid, 0);

    // FRAME_LEN=1: single accept goes straight to DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    send(9, 9, 9, 9);
    chk("fl1_oval",  c_out_valid, 1);
    chk("fl1_sum",   c_sum, 9);
    chk("fl1_ready", c_in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("fl1_hs_oval", c_out_valid, 0);
    chk("fl1_hs_sum",  c_sum, 0);

    // Mismatch counter saturates at 15 after 32 mismatching accepts
    in_valid = 1'b1;
    sq_g = 1; sq_d = 2; sq_if = 1; sq_c = 1;
    for (int k = 0; k < 40; k++) tick();
    in_valid = 1'b0;
    tick();
    chk("mcnt_sat_a", a_mcnt, 15);
    chk("mcnt_sat_c", c_mcnt, 15);
    chk("mcnt_flag",  a_mismatch, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
